mm_write_arbiter: RTL and testbench

MM_WRITE_ARBITER -- requirements
Module: mm_write_arbiter

---
 rtl/mm_write_arbiter.sv | 115 +++++++++++
 tb/tb_mm_write_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_write_arbiter.sv
// Round-robin arbiter granting one of num_req_p requesters access to the
// matrix memory write port, then sequencing strobe, wait-for-ready and done.
package mm_write_arbiter_pkg;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } point_t;
endpackage

module mm_write_arbiter
  import mm_write_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p = 3
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  point_t [num_req_p-1:0]           req_addr_i,
  input  logic [num_req_p-1:0][3:0][3:0]   req_data_i,
  output logic [num_req_p-1:0]             grant_o,
  output logic [num_req_p-1:0]             done_o,
  output logic                             busy_o,
  output point_t                           mm_write_addr_o,
  output logic [3:0][3:0]                  mm_write_data_o,
  output logic                             mm_write_v_o,
  input  logic                             mm_is_ready_i
);

  localparam int unsigned idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [num_req_p-1:0] one_hot_base = {{(num_req_p-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [idx_w-1:0] rr_q;
  logic [idx_w-1:0] win_q;
  logic [idx_w-1:0] win_idx;
  logic [idx_w-1:0] cand_idx;
  logic             win_found;
  logic             take;
  int unsigned      cand;
  point_t           addr_q;
  logic [3:0][3:0]  data_q;

  // Scan from rr_q upward, wrapping modulo num_req_p; first requester found wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= num_req_p) cand = cand - num_req_p;
      cand_idx = idx_w'(cand);
      if (!win_found && req_v_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign take = (state_q == S_IDLE) && mm_is_ready_i && win_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (mm_is_ready_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are masked during reset so an aborted transaction never reports done.
  always_comb begin
    grant_o      = '0;
    done_o       = '0;
    busy_o       = 1'b0;
    mm_write_v_o = 1'b0;
    if (!reset_i) begin
      if (take) grant_o = one_hot_base << win_idx;
      if (state_q == S_DONE) done_o = one_hot_base << win_q;
      busy_o       = (state_q != S_IDLE);
      mm_write_v_o = (state_q == S_ISSUE);
    end
  end

  assign mm_write_addr_o = addr_q;
  assign mm_write_data_o = data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        win_q  <= win_idx;
        addr_q <= req_addr_i[win_idx];
        data_q <= req_data_i[win_idx];
        rr_q   <= (win_idx == idx_w'(num_req_p - 1)) ? '0 : win_idx + idx_w'(1);
      end
    end
  end

endmodule

// File: tb/tb_mm_write_arbiter.sv
// Scoreboard bench for mm_write_arbiter: a timing-level reference model predicts
// grants, strobes, dones and busy; a separate monitor compares DUT outputs.
module tb_mm_write_arbiter;
  import mm_write_arbiter_pkg::*;

  localparam int N = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N-1:0]            req_v = '0;
  point_t [N-1:0]          req_addr = '0;
  logic [N-1:0][3:0][3:0]  req_data = '0;
  logic [N-1:0]            grant, done;
  logic                    busy, wv, ready;
  point_t                  wa;
  logic [3:0][3:0]         wd;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  mem_cnt  = 0;
  int  slow_delay = 0;
  bit  hold_off = 1'b0;
  bit  auto_rerq = 1'b0;
  logic [N-1:0] gseen = '0;

  typedef struct {
    int        cyc;
    int        idx;
    point_t    a;
    logic [15:0] d;
  } exp_t;

  exp_t gq[$];
  exp_t wq[$];
  exp_t dq[$];
  bit   bq[$];

  mm_write_arbiter #(.num_req_p(N)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .req_v_i        (req_v),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .grant_o        (grant),
    .done_o         (done),
    .busy_o         (busy),
    .mm_write_addr_o(wa),
    .mm_write_data_o(wd),
    .mm_write_v_o   (wv),
    .mm_is_ready_i  (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: after each strobe it stays busy for slow_delay cycles.
  always @(posedge clk) begin
    if (rst) mem_cnt <= 0;
    else if (wv) mem_cnt <= slow_delay;
    else if (mem_cnt > 0) mem_cnt <= mem_cnt - 1;
  end
  assign ready = (mem_cnt == 0) && !hold_off;

  always @(negedge clk) begin
    #2;
    gseen <= grant;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s cycle %0d", nm, cyc);
  endtask

  // Reference model: arbiter is free from m_free; when ready and someone
  // requests, the round-robin winner is granted; done follows the first
  // ready sample at least two cycles after the grant.
  int  m_free = 0, m_rr = 0, m_win = 0, m_wait_from = 0, m_done_cyc = -1, mk = 0, mw = 0;
  bit  m_wait = 1'b0, m_eb = 1'b0, m_found = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_eb = 1'b0; m_wait = 1'b0; m_rr = 0; m_free = cyc + 1; m_done_cyc = -1;
      gq.delete(); wq.delete(); dq.delete();
    end else begin
      m_eb = m_wait || (cyc == m_done_cyc);
      if (m_wait) begin
        if (cyc >= m_wait_from && ready) begin
          dq.push_back('{cyc + 1, m_win, '0, '0});
          m_done_cyc = cyc + 1;
          m_free = cyc + 2;
          m_wait = 1'b0;
        end
      end else if (cyc >= m_free && ready && req_v != '0) begin
        m_found = 1'b0;
        mw = 0;
        for (int i = 0; i < N; i++) begin
          mk = (m_rr + i) % N;
          if (!m_found && req_v[mk]) begin m_found = 1'b1; mw = mk; end
        end
        gq.push_back('{cyc, mw, '0, '0});
        wq.push_back('{cyc + 1, mw, req_addr[mw], req_data[mw]});
        m_win = mw;
        m_wait = 1'b1;
        m_wait_from = cyc + 2;
        m_rr = (mw + 1) % N;
      end
    end
    bq.push_back(m_eb);
  end

  // Monitor
  exp_t   e;
  point_t cur_a = '0;
  logic [15:0] cur_d = '0;
  bit     eb_m;

  always @(negedge clk) begin
    #1;
    if (bq.size() == 0) fail_now("busy_queue_empty");
    else begin
      eb_m = bq.pop_front();
      check("busy", 32'(busy), 32'(eb_m));
    end
    if (grant != '0) begin
      if (gq.size() == 0 || gq[0].cyc != cyc) fail_now("grant_unexpected");
      else begin e = gq.pop_front(); check("grant", 32'(grant), 32'(1) << e.idx); end
    end
    while (gq.size() > 0 && gq[0].cyc <= cyc) begin void'(gq.pop_front()); fail_now("grant_missing"); end
    if (wv) begin
      if (wq.size() == 0 || wq[0].cyc != cyc) fail_now("strobe_unexpected");
      else begin
        e = wq.pop_front();
        cur_a = e.a; cur_d = e.d;
        check("wr_addr", 32'(wa), 32'(e.a));
        check("wr_data", 32'(wd), 32'(e.d));
      end
    end
    while (wq.size() > 0 && wq[0].cyc <= cyc) begin void'(wq.pop_front()); fail_now("strobe_missing"); end
    if (done != '0) begin
      if (dq.size() == 0 || dq[0].cyc != cyc) fail_now("done_unexpected");
      else begin e = dq.pop_front(); check("done", 32'(done), 32'(1) << e.idx); end
    end
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin void'(dq.pop_front()); fail_now("done_missing"); end
    if (grant != '0 && done != '0) fail_now("grant_with_done");
    if (busy && !wv) begin
      check("hold_addr", 32'(wa), 32'(cur_a));
      check("hold_data", 32'(wd), 32'(cur_d));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_v = (req_v & ~gseen) | (auto_rerq ? gseen : '0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic raise(input int k, input logic [3:0] x, input logic [3:0] y, input logic [15:0] d);
    req_addr[k] = '{x: x, y: y};
    req_data[k] = d;
    req_v[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic check_idle_zero();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wv", 32'(wv), 0);
    check("rst_addr", 32'(wa), 0);
    check("rst_data", 32'(wd), 0);
  endtask

  initial begin
    ticks(3);
    rst = 1'b0;
    check_idle_zero();

    // Single request
    raise(1, 4'd5, 4'd10, 16'h0660);
    ticks(8);

    // Contention, requests held from reset
    rst = 1'b1;
    raise(0, 4'd1, 4'd2, 16'h1111);
    raise(1, 4'd3, 4'd4, 16'h2222);
    raise(2, 4'd6, 4'd7, 16'h4444);
    auto_rerq = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(16);
    auto_rerq = 1'b0;
    req_v = '0;
    ticks(6);

    // Slow memory
    slow_delay = 5;
    raise(2, 4'd9, 4'd8, 16'hF00F);
    ticks(14);
    slow_delay = 0;

    // Not ready in IDLE
    hold_off = 1'b1;
    raise(0, 4'd2, 4'd3, 16'h0FF0);
    ticks(3);
    check("no_grant_not_ready", 32'(grant), 0);
    hold_off = 1'b0;
    ticks(6);

    // Reset while waiting on memory
    slow_delay = 8;
    raise(1, 4'd11, 4'd12, 16'hABCD);
    ticks(4);
    rst = 1'b1;
    #3;
    check("rstwait_done", 32'(done), 0);
    check("rstwait_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    slow_delay = 0;
    check_idle_zero();
    raise(2, 4'd4, 4'd4, 16'h8001);
    ticks(6);
    raise(0, 4'd7, 4'd1, 16'h1234);
    raise(1, 4'd8, 4'd2, 16'h5678);
    ticks(10);

    // Wrap of the round-robin pointer
    do_reset();
    raise(1, 4'd1, 4'd1, 16'h0001);
    ticks(6);
    raise(0, 4'd2, 4'd2, 16'h0002);
    raise(2, 4'd3, 4'd3, 16'h0003);
    ticks(12);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if (!req_v[k] && $urandom_range(0, 3) == 0)
          raise(k, 4'($urandom), 4'($urandom), 16'($urandom));
      slow_delay = $urandom_range(0, 3);
      hold_off = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end
    rst = 1'b0;
    hold_off = 1'b0;
    slow_delay = 0;
    req_v = '0;
    ticks(20);
    check("leftover", 32'(gq.size() + wq.size() + dq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
